// File: rtl/word_packer_pkg.sv
// Shared definitions for the word_packer slice: default geometry, derived widths, FSM encoding.
// Optional early frame close is enabled by defining WORD_PACKER_PAD_EN.
package word_packer_pkg;

    localparam int N_WORDS_DEF = 12;
    localparam int NB_DATA_DEF = 8;
    localparam int NB_BUS      = N_WORDS_DEF * NB_DATA_DEF;
    localparam int NB_CNT      = $clog2(N_WORDS_DEF + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/word_packer_ctrl.sv
// Frame control for word_packer: FILL/HOLD FSM, word counter, handshake outputs, slot write enables.
// With WORD_PACKER_PAD_EN defined, i_last on an accepted word closes the frame early.
module word_packer_ctrl
    import word_packer_pkg::*;
#(
    parameter int N_WORDS = N_WORDS_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           i_valid,
    input  logic                           i_last,
    input  logic                           i_ready,
    output logic                           o_ready,
    output logic                           o_valid,
    output logic [$clog2(N_WORDS+1)-1:0]   o_count,
    output logic [N_WORDS-1:0]             wr_en_o,
    output logic                           clr_o
);

    localparam int CW = $clog2(N_WORDS + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            accept;
    logic            close;

    assign accept = i_valid && ready_q;

`ifdef WORD_PACKER_PAD_EN
    assign close = (cnt_q == CW'(N_WORDS - 1)) || i_last;
`else
    logic unused_last;
    assign unused_last = i_last;
    assign close = (cnt_q == CW'(N_WORDS - 1));
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        ready_d = ready_q;
        valid_d = valid_q;
        wr_en_o = '0;
        clr_o   = 1'b0;

        case (state_q)
            FILL: begin
                // ready_q is low only on the first cycle after reset release
                ready_d = 1'b1;
                if (accept) begin
                    for (int k = 0; k < N_WORDS; k++) begin
                        wr_en_o[k] = (cnt_q == CW'(k));
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (close) begin
                        state_d = HOLD;
                        ready_d = 1'b0;
                        valid_d = 1'b1;
                        count_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (i_ready) begin
                    clr_o   = 1'b1;
                    state_d = FILL;
                    cnt_d   = '0;
                    count_d = '0;
                    ready_d = 1'b1;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_count = count_q;

endmodule

// File: rtl/word_packer.sv
// Serial-to-parallel word packer feeding the sum-of-products multiplier; word k lands at bits [(k+1)*NB_DATA-1 -: NB_DATA].
// Define WORD_PACKER_PAD_EN to let i_last close a short, zero-padded frame.
module word_packer
    import word_packer_pkg::*;
#(
    parameter int N_WORDS = N_WORDS_DEF,
    parameter int NB_DATA = NB_DATA_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NB_DATA-1:0]             i_data,
    input  logic                           i_valid,
    input  logic                           i_last,
    output logic                           o_ready,
    output logic [N_WORDS*NB_DATA-1:0]     o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [$clog2(N_WORDS+1)-1:0]   o_count
);

    logic [N_WORDS-1:0] wr_en;
    logic               clr;
    logic [NB_DATA-1:0] slot_q [N_WORDS];

    word_packer_ctrl #(
        .N_WORDS (N_WORDS)
    ) u_ctrl (
        .clock   (clock),
        .reset   (reset),
        .i_valid (i_valid),
        .i_last  (i_last),
        .i_ready (i_ready),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_count (o_count),
        .wr_en_o (wr_en),
        .clr_o   (clr)
    );

    // Clearing on handshake keeps unused slots at zero, a neutral pad for the multiplier
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_WORDS; k++) begin
                slot_q[k] <= '0;
            end
        end else if (clr) begin
            for (int k = 0; k < N_WORDS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_WORDS; k++) begin
                if (wr_en[k]) begin
                    slot_q[k] <= i_data;
                end
            end
        end
    end

    for (genvar g = 0; g < N_WORDS; g++) begin : g_bus
        assign o_data[(g+1)*NB_DATA-1 -: NB_DATA] = slot_q[g];
    end

endmodule

// File: tb/tb_word_packer.sv
// Directed plus randomized bench for word_packer against a queue-based frame model.
module tb_word_packer;

    localparam int NW   = 12;
    localparam int NB   = 8;
    localparam int NBUS = NW * NB;
    localparam int NC   = $clog2(NW + 1);
`ifdef WORD_PACKER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic            clock   = 1'b0;
    logic            reset   = 1'b0;
    logic [NB-1:0]   i_data  = '0;
    logic            i_valid = 1'b0;
    logic            i_last  = 1'b0;
    logic            i_ready = 1'b0;
    logic            o_ready;
    logic [NBUS-1:0] o_data;
    logic            o_valid;
    logic [NC-1:0]   o_count;

    word_packer #(.N_WORDS(NW), .NB_DATA(NB)) dut (
        .clock   (clock),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_count (o_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference: a frame is the list of words accepted since the last handoff
    logic [NB-1:0] m_words[$];
    bit            m_ready;
    bit            m_valid;
    logic [NC-1:0] m_count;

    function automatic logic [NBUS-1:0] packed_model();
        logic [NBUS-1:0] v = '0;
        for (int k = 0; k < m_words.size(); k++) v[k*NB +: NB] = m_words[k];
        return v;
    endfunction

    task automatic check(input string tag, input logic [NBUS-1:0] obs, input logic [NBUS-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_count = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ready"}, NBUS'(o_ready), NBUS'(m_ready));
        check({tag, ".valid"}, NBUS'(o_valid), NBUS'(m_valid));
        check({tag, ".data"},  o_data, packed_model());
        if (m_valid || !reset) check({tag, ".count"}, NBUS'(o_count), NBUS'(m_count));
    endtask

    task automatic step(input string tag);
        bit was_ready;
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else if (m_valid) begin
            if (i_ready) begin
                m_words.delete();
                m_valid = 1'b0;
                m_ready = 1'b1;
                m_count = '0;
            end
        end else begin
            was_ready = m_ready;
            m_ready = 1'b1;
            if (i_valid && was_ready) begin
                m_words.push_back(i_data);
                if (m_words.size() == NW || (PAD && i_last)) begin
                    m_valid = 1'b1;
                    m_ready = 1'b0;
                    m_count = NC'(m_words.size());
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input logic [NB-1:0] d, input bit l, input bit r);
        i_valid = v;
        i_data  = d;
        i_last  = l;
        i_ready = r;
    endtask

    initial begin
        logic [NBUS-1:0] held;
        model_reset();

        // 1. reset held low for three cycles, then release
        #1;
        check_all("rst_async");
        repeat (3) step("rst");
        reset = 1'b1;
        step("rst_release");
        check("rst_release.ready_hi", NBUS'(o_ready), NBUS'(1'b1));

        // 2. full frame back to back
        for (int i = 1; i <= NW; i++) begin
            drive(1'b1, NB'(i), 1'b0, 1'b1);
            step("full");
        end
        check("full.valid", NBUS'(o_valid), NBUS'(1'b1));
        check("full.data", o_data, 96'h0C0B0A090807060504030201);
        check("full.count", NBUS'(o_count), NBUS'(NW));
        drive(1'b0, '0, 1'b0, 1'b1);
        step("full_hs");
        check("full_hs.ready", NBUS'(o_ready), NBUS'(1'b1));

        // 3. random input gaps during FILL, then downstream backpressure
        for (int c = 0; c < 200 && !m_valid; c++) begin
            drive(1'($urandom % 2), NB'($urandom), 1'b0, 1'b0);
            step("gap_fill");
        end
        check("gap_fill.closed", NBUS'(o_valid), NBUS'(1'b1));
        held = o_data;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, NB'($urandom), 1'b0, 1'b0);
            step("bp_hold");
            check("bp_hold.stable", o_data, held);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        step("bp_hs");

        // 4. negative words pass through without sign extension
        for (int i = 0; i < NW; i++) begin
            drive(1'b1, (i % 2 == 0) ? 8'h80 : 8'hFF, 1'b0, 1'b0);
            step("neg");
        end
        check("neg.slot0", NBUS'(o_data[7:0]), NBUS'(8'h80));
        check("neg.slot1", NBUS'(o_data[15:8]), NBUS'(8'hFF));
        drive(1'b0, '0, 1'b0, 1'b1);
        step("neg_hs");

        // 5. asynchronous reset after seven accepts
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, NB'($urandom | 1), 1'b0, 1'b0);
            step("mid");
        end
        reset = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst_async");
        step("mid_rst");
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        step("mid_release");
        for (int i = 0; i < NW; i++) begin
            drive(1'b1, NB'($urandom), 1'b0, 1'b0);
            step("post_rst");
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        step("post_rst_hs");

        // 6. short frame with i_last on the fifth word
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, NB'(8'h11 + i), (i == 4), 1'b0);
            step("last");
        end
`ifdef WORD_PACKER_PAD_EN
        check("last.valid", NBUS'(o_valid), NBUS'(1'b1));
        check("last.count", NBUS'(o_count), NBUS'(5));
        check("last.data", o_data, 96'h1514131211);
`else
        check("last.no_valid", NBUS'(o_valid), NBUS'(1'b0));
        for (int i = 5; i < NW; i++) begin
            drive(1'b1, NB'(8'h11 + i), 1'b0, 1'b0);
            step("last_rest");
        end
        check("last.valid12", NBUS'(o_valid), NBUS'(1'b1));
        check("last.count12", NBUS'(o_count), NBUS'(NW));
`endif
        drive(1'b0, '0, 1'b0, 1'b1);
        step("last_hs");

        // randomized soak of both handshakes
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, NB'($urandom), ($urandom % 8) == 0, ($urandom % 3) == 0);
            step("soak");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
